// File: rtl/pixel_out_buffer.sv
// pixel_out_buffer: output FIFO behind data_proc. The CPU drains it through a
// small register window. The block applies backpressure when the FIFO is full
// and raises a level-threshold interrupt.
// Ports:
//   clk, rstn            clock; synchronous active-high reset (1 = reset)
//   in_valid/in_pixel    pixel stream from data_proc
//   in_ready             combinational accept (enable & ~full)
//   reg_addr/reg_wr/reg_wdata/reg_rd/reg_rdata
//                        register window: 0x0 DATA, 0x4 STATUS, 0x8 CTRL
//   irq                  registered level interrupt
module pixel_out_buffer #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned PIX_W = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  input  logic [PIX_W-1:0] in_pixel,
  output logic             in_ready,
  input  logic [3:0]       reg_addr,
  input  logic             reg_wr,
  input  logic [31:0]      reg_wdata,
  input  logic             reg_rd,
  output logic [31:0]      reg_rdata,
  output logic             irq
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;

  localparam logic [3:0] ADDR_DATA   = 4'h0;
  localparam logic [3:0] ADDR_STATUS = 4'h4;
  localparam logic [3:0] ADDR_CTRL   = 4'h8;

  logic [PIX_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr, rptr;
  logic [LVL_W-1:0] level;
  logic             enable;
  logic [7:0]       threshold;
  logic             underflow;

  logic [PTR_W-1:0] wptr_nxt, rptr_nxt;
  logic [LVL_W-1:0] level_nxt;
  logic             enable_nxt;
  logic [7:0]       threshold_nxt;
  logic             underflow_nxt;
  logic [31:0]      rdata_nxt;
  logic             irq_nxt;

  logic full, empty, push, pop, rd_acc, flush;

  logic unused_wdata;
  assign unused_wdata = ^{reg_wdata[31:16], reg_wdata[7:3]};

  assign full     = (level == LVL_W'(DEPTH));
  assign empty    = (level == '0);
  assign in_ready = enable & ~full;

  // A write strobe wins over a simultaneous read strobe.
  assign rd_acc = reg_rd & ~reg_wr;
  assign flush  = reg_wr & (reg_addr == ADDR_CTRL) & reg_wdata[1];
  assign push   = in_valid & in_ready & ~flush;
  assign pop    = rd_acc & (reg_addr == ADDR_DATA) & ~empty;

  // Next-state for pointers, level, control registers and read data.
  always_comb begin
    wptr_nxt      = wptr;
    rptr_nxt      = rptr;
    level_nxt     = level;
    enable_nxt    = enable;
    threshold_nxt = threshold;
    underflow_nxt = underflow;
    rdata_nxt     = 32'd0;

    if (flush) begin
      wptr_nxt  = '0;
      rptr_nxt  = '0;
      level_nxt = '0;
    end else begin
      if (push) wptr_nxt = wptr + PTR_W'(1);
      if (pop)  rptr_nxt = rptr + PTR_W'(1);
      level_nxt = level + LVL_W'(push) - LVL_W'(pop);
    end

    if (reg_wr) begin
      if (reg_addr == ADDR_STATUS && reg_wdata[2]) underflow_nxt = 1'b0;
      if (reg_addr == ADDR_CTRL) begin
        enable_nxt    = reg_wdata[0];
        threshold_nxt = reg_wdata[15:8];
      end
    end else if (rd_acc) begin
      case (reg_addr)
        ADDR_DATA: begin
          if (empty) underflow_nxt = 1'b1;
          else       rdata_nxt     = 32'(mem[rptr]);
        end
        ADDR_STATUS: rdata_nxt = {16'd0, 8'(level), 4'd0, enable, underflow, full, empty};
        ADDR_CTRL:   rdata_nxt = {16'd0, threshold, 7'd0, enable};
        default:     rdata_nxt = 32'd0;
      endcase
    end

    // Compared against the post-update level; an unreachable threshold never fires.
    irq_nxt = enable & (threshold != 8'd0) & (8'(level_nxt) >= threshold);
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rstn) begin
      wptr      <= '0;
      rptr      <= '0;
      level     <= '0;
      enable    <= 1'b0;
      threshold <= 8'd0;
      underflow <= 1'b0;
      reg_rdata <= 32'd0;
      irq       <= 1'b0;
    end else begin
      wptr      <= wptr_nxt;
      rptr      <= rptr_nxt;
      level     <= level_nxt;
      enable    <= enable_nxt;
      threshold <= threshold_nxt;
      underflow <= underflow_nxt;
      reg_rdata <= rdata_nxt;
      irq       <= irq_nxt;
    end
  end

  // Pixel storage; contents need no reset since level gates visibility.
  always_ff @(posedge clk) begin
    if (push && !rstn) mem[wptr] <= in_pixel;
  end

endmodule

// File: tb/tb_pixel_out_buffer.sv
module tb_pixel_out_buffer;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic [7:0]  in_pixel;
  logic        in_ready;
  logic [3:0]  reg_addr;
  logic        reg_wr;
  logic [31:0] reg_wdata;
  logic        reg_rd;
  logic [31:0] reg_rdata;
  logic        irq;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb[$];

  pixel_out_buffer #(.DEPTH(16), .PIX_W(8)) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_pixel(in_pixel), .in_ready(in_ready),
    .reg_addr(reg_addr), .reg_wr(reg_wr), .reg_wdata(reg_wdata),
    .reg_rd(reg_rd), .reg_rdata(reg_rdata), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic reg_write(input logic [3:0] a, input logic [31:0] d);
    reg_addr = a; reg_wdata = d; reg_wr = 1'b1;
    tick();
    reg_wr = 1'b0;
  endtask

  task automatic reg_read(input logic [3:0] a, output logic [31:0] d);
    reg_addr = a; reg_rd = 1'b1;
    tick();
    reg_rd = 1'b0;
    d = reg_rdata;
  endtask

  // Push one pixel, waiting a bounded number of cycles for in_ready.
  task automatic push_pix(input logic [7:0] p);
    int n = 0;
    in_valid = 1'b1; in_pixel = p;
    while (!in_ready && n < 50) begin tick(); n++; end
    if (!in_ready) begin
      check("push_timeout", 32'(in_ready), 32'd1);
    end else begin
      sb.push_back(p);
      tick();
    end
    in_valid = 1'b0;
  endtask

  // DATA read compared against the scoreboard head (0 when empty).
  task automatic pop_check(input string tag);
    logic [31:0] d, e;
    e = (sb.size() > 0) ? 32'(sb.pop_front()) : 32'd0;
    reg_read(4'h0, d);
    check(tag, d, e);
  endtask

  initial begin
    logic [31:0] d;
    rstn = 1'b1; in_valid = 1'b0; in_pixel = 8'h00;
    reg_addr = 4'h0; reg_wr = 1'b0; reg_wdata = 32'd0; reg_rd = 1'b0;

    // T1 reset
    tick(); tick();
    rstn = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    check("rst_rdata", reg_rdata, 32'd0);
    reg_read(4'h4, d); check("rst_status", d, 32'h1);

    // T2 ordering
    reg_write(4'h8, 32'h1);
    push_pix(8'h11); push_pix(8'h22); push_pix(8'h33);
    pop_check("order0"); pop_check("order1"); pop_check("order2");
    reg_read(4'h4, d); check("t2_status", d, 32'h9);

    // T3 full with in_valid held
    in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      in_pixel = 8'(8'h40 + i);
      if (in_ready) sb.push_back(in_pixel);
      tick();
    end
    check("full_in_ready", 32'(in_ready), 32'd0);
    check("full_sb_size", 32'(sb.size()), 32'd16);
    reg_read(4'h4, d); check("full_status", d, 32'h0000_100A);
    in_pixel = 8'hA5;
    pop_check("full_pop");
    check("full_ready_after_pop", 32'(in_ready), 32'd1);
    sb.push_back(8'hA5);
    tick();
    in_valid = 1'b0;
    check("full_again", 32'(in_ready), 32'd0);
    for (int i = 0; i < 16; i++) pop_check("full_drain");

    // T4 underflow
    pop_check("uf_data");
    reg_read(4'h4, d); check("uf_status", d, 32'hD);
    reg_write(4'h4, 32'h4);
    reg_read(4'h4, d); check("uf_cleared", d, 32'h9);

    // T5 irq threshold
    reg_write(4'h8, 32'h0401);
    push_pix(8'h01); push_pix(8'h02); push_pix(8'h03);
    check("irq_below", 32'(irq), 32'd0);
    push_pix(8'h04);
    check("irq_at_thr", 32'(irq), 32'd1);
    pop_check("irq_pop");
    check("irq_drop", 32'(irq), 32'd0);
    for (int i = 0; i < 3; i++) pop_check("irq_drain");

    // Threshold above depth never fires
    reg_write(4'h8, 32'h1101);
    for (int i = 0; i < 16; i++) push_pix(8'(8'h80 + i));
    check("irq_thr_gt_depth", 32'(irq), 32'd0);
    for (int i = 0; i < 16; i++) pop_check("gt_drain");
    reg_write(4'h8, 32'h1);

    // T6 simultaneous push/pop across pointer wrap
    push_pix(8'hC0);
    for (int i = 0; i < 40; i++) begin
      logic [7:0] e;
      in_valid = 1'b1; in_pixel = 8'(8'hC1 + i);
      reg_addr = 4'h0; reg_rd = 1'b1;
      e = sb.pop_front();
      sb.push_back(in_pixel);
      tick();
      reg_rd = 1'b0; in_valid = 1'b0;
      check("wrap_pair", reg_rdata, 32'(e));
    end
    reg_read(4'h4, d); check("wrap_status", d, 32'h0000_0108);
    pop_check("wrap_last");
    for (int i = 0; i < 5; i++) push_pix(8'(8'h60 + i));
    in_valid = 1'b1; in_pixel = 8'hEE;
    reg_write(4'h8, 32'h3);
    in_valid = 1'b0;
    sb.delete();
    reg_read(4'h4, d); check("flush_status", d, 32'h9);
    reg_read(4'h8, d); check("ctrl_readback", d, 32'h1);
    pop_check("flush_discarded");
    reg_read(4'hC, d); check("unmapped_read", d, 32'h0);

    // Write wins over a simultaneous read; disable drops in_ready
    reg_addr = 4'h4; reg_wdata = 32'h4; reg_wr = 1'b1; reg_rd = 1'b1;
    tick();
    reg_wr = 1'b0; reg_rd = 1'b0;
    check("wr_wins_rdata", reg_rdata, 32'h0);
    reg_read(4'h4, d); check("wr_wins_status", d, 32'h9);
    reg_write(4'h8, 32'h0);
    check("disable_ready", 32'(in_ready), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
